timer_cmp_rd: RTL and testbench

Read-side and compare companion to the timer counter. It consumes the live 64-bit count and holds the 64-bit compare register, interrupt enable and sticky interrupt status. It returns register read data with a coherent 64-bit counter snapshot. It sits between the bus register interface and the interrupt line, alongside the counter on the same addr/wdata/wr_en bus.

---
 rtl/timer_pkg.sv | 16 +
 rtl/timer_int_ctrl.sv | 33 +++
 rtl/timer_cmp_rd.sv | 98 +++++++++
 tb/tb_timer_cmp_rd.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared timer definitions: register map, interrupt bit position and compare reset value.
package timer_pkg;

  localparam int unsigned ADDR_TDR0  = 32'h004;
  localparam int unsigned ADDR_TDR1  = 32'h008;
  localparam int unsigned ADDR_TCMP0 = 32'h00C;
  localparam int unsigned ADDR_TCMP1 = 32'h010;
  localparam int unsigned ADDR_TIER  = 32'h014;
  localparam int unsigned ADDR_TISR  = 32'h018;

  localparam int unsigned INT_BIT = 0;

  // All-ones keeps a freshly reset counter at 0 from matching.
  localparam logic [63:0] CMP_RST_DEF = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage : timer_pkg

// File: rtl/timer_int_ctrl.sv
// Compare-match edge detection, sticky status with set-over-clear priority, and gated interrupt line.
module timer_int_ctrl (
  input  logic clk,
  input  logic rst_n,
  input  logic match_raw,
  input  logic cmp_wr,
  input  logic st_clr,
  input  logic int_en_nxt,
  output logic int_st,
  output logic tim_int
);

  logic match_q;
  logic set_c;
  logic int_st_nxt;

  // A compare write masks this cycle's edge and re-arms detection for the next one.
  assign set_c      = match_raw & ~match_q & ~cmp_wr;
  assign int_st_nxt = set_c | (int_st & ~st_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= 1'b0;
      int_st  <= 1'b0;
      tim_int <= 1'b0;
    end else begin
      match_q <= cmp_wr ? 1'b0 : match_raw;
      int_st  <= int_st_nxt;
      tim_int <= int_st_nxt & int_en_nxt;
    end
  end

endmodule : timer_int_ctrl

// File: rtl/timer_cmp_rd.sv
// Timer compare/status registers and registered read path with coherent 64-bit counter snapshot.
module timer_cmp_rd
  import timer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter logic [63:0] CMP_RST = CMP_RST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [63:0]       cnt_value,
  output logic [31:0]       rdata,
  output logic              rd_valid,
  output logic              tim_int
);

  logic        sel_tdr0, sel_tdr1, sel_tcmp0, sel_tcmp1, sel_tier, sel_tisr;
  logic [63:0] compare;
  logic [31:0] snap_hi;
  logic [31:0] rd_mux;
  logic        int_en;
  logic        int_en_nxt;
  logic        int_st;
  logic        cmp_wr;
  logic        st_clr;
  logic        match_raw;

  assign sel_tdr0  = (addr == ADDR_W'(ADDR_TDR0));
  assign sel_tdr1  = (addr == ADDR_W'(ADDR_TDR1));
  assign sel_tcmp0 = (addr == ADDR_W'(ADDR_TCMP0));
  assign sel_tcmp1 = (addr == ADDR_W'(ADDR_TCMP1));
  assign sel_tier  = (addr == ADDR_W'(ADDR_TIER));
  assign sel_tisr  = (addr == ADDR_W'(ADDR_TISR));

  assign cmp_wr     = wr_en & (sel_tcmp0 | sel_tcmp1);
  assign st_clr     = wr_en & sel_tisr & wdata[INT_BIT];
  assign int_en_nxt = (wr_en & sel_tier) ? wdata[INT_BIT] : int_en;
  assign match_raw  = (cnt_value == compare);

  // Read mux sees pre-write register values, so a same-cycle write is not visible.
  always_comb begin
    rd_mux = '0;
    if (sel_tdr0) begin
      rd_mux = cnt_value[31:0];
    end else if (sel_tdr1) begin
      rd_mux = snap_hi;
    end else if (sel_tcmp0) begin
      rd_mux = compare[31:0];
    end else if (sel_tcmp1) begin
      rd_mux = compare[63:32];
    end else if (sel_tier) begin
      rd_mux[INT_BIT] = int_en;
    end else if (sel_tisr) begin
      rd_mux[INT_BIT] = int_st;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      compare <= CMP_RST;
      int_en  <= 1'b0;
    end else begin
      if (wr_en && sel_tcmp0) compare[31:0]  <= wdata;
      if (wr_en && sel_tcmp1) compare[63:32] <= wdata;
      int_en <= int_en_nxt;
    end
  end

  // High word is captured alongside the low-word read so TDR0 then TDR1 is coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata    <= '0;
      rd_valid <= 1'b0;
      snap_hi  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rdata <= rd_mux;
        if (sel_tdr0) snap_hi <= cnt_value[63:32];
      end
    end
  end

  timer_int_ctrl u_int_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .match_raw  (match_raw),
    .cmp_wr     (cmp_wr),
    .st_clr     (st_clr),
    .int_en_nxt (int_en_nxt),
    .int_st     (int_st),
    .tim_int    (tim_int)
  );

endmodule : timer_cmp_rd

// File: tb/tb_timer_cmp_rd.sv
// Self-checking bench for timer_cmp_rd: reset table, directed corner sequences, random run vs. register model.
module tb_timer_cmp_rd;
  import timer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        wr_en;
  logic        rd_en;
  logic [63:0] cnt_value;
  logic [31:0] rdata;
  logic        rd_valid;
  logic        tim_int;

  int n_checks = 0;
  int n_err    = 0;

  // Register-level model of the block's architectural state
  logic [63:0] m_cmp;
  logic        m_en, m_st, m_tim, m_prev_eq;
  logic [31:0] m_snap, m_rdata;

  localparam logic [11:0] A_TDR0  = 12'(ADDR_TDR0);
  localparam logic [11:0] A_TDR1  = 12'(ADDR_TDR1);
  localparam logic [11:0] A_TCMP0 = 12'(ADDR_TCMP0);
  localparam logic [11:0] A_TCMP1 = 12'(ADDR_TCMP1);
  localparam logic [11:0] A_TIER  = 12'(ADDR_TIER);
  localparam logic [11:0] A_TISR  = 12'(ADDR_TISR);

  typedef struct {
    logic [11:0] a;
    logic [63:0] cnt;
    logic [31:0] exp;
  } vec_t;

  timer_cmp_rd dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .wdata     (wdata),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .cnt_value (cnt_value),
    .rdata     (rdata),
    .rd_valid  (rd_valid),
    .tim_int   (tim_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    m_en = 1'b0; m_st = 1'b0; m_tim = 1'b0; m_prev_eq = 1'b0;
    m_snap = '0; m_rdata = '0;
  endtask

  // One bus cycle: drive inputs, advance the model, check all outputs after the edge.
  task automatic step(input logic [11:0] a, input logic [31:0] wd, input logic w,
                      input logic r, input logic [63:0] c);
    logic [31:0] rv;
    logic eq, rise, clr, cw;
    addr = a; wdata = wd; wr_en = w; rd_en = r; cnt_value = c;
    case (a)
      A_TDR0:  rv = c[31:0];
      A_TDR1:  rv = m_snap;
      A_TCMP0: rv = m_cmp[31:0];
      A_TCMP1: rv = m_cmp[63:32];
      A_TIER:  rv = {31'b0, m_en};
      A_TISR:  rv = {31'b0, m_st};
      default: rv = '0;
    endcase
    if (r) begin
      m_rdata = rv;
      if (a == A_TDR0) m_snap = c[63:32];
    end
    cw   = w && (a == A_TCMP0 || a == A_TCMP1);
    eq   = (c == m_cmp);
    rise = eq && !m_prev_eq && !cw;
    m_prev_eq = eq && !cw;
    clr  = w && (a == A_TISR) && wd[0];
    m_st = rise || (m_st && !clr);
    if (w && a == A_TIER)  m_en = wd[0];
    if (w && a == A_TCMP0) m_cmp[31:0] = wd;
    if (w && a == A_TCMP1) m_cmp[63:32] = wd;
    m_tim = m_st && m_en;
    @(posedge clk); #1;
    chk("rd_valid", 64'(rd_valid), 64'(r));
    chk("rdata", 64'(rdata), 64'(m_rdata));
    chk("tim_int", 64'(tim_int), 64'(m_tim));
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [63:0] c);
    step(a, d, 1'b1, 1'b0, c);
  endtask

  task automatic rd(input logic [11:0] a, input logic [63:0] c);
    step(a, 32'h0, 1'b0, 1'b1, c);
  endtask

  initial begin
    vec_t tbl[8];
    logic [63:0] c;
    logic [11:0] addrs[8];
    logic [11:0] ra;
    logic [31:0] rw;

    tbl[0] = '{A_TCMP0, 64'h0, 32'hFFFF_FFFF};
    tbl[1] = '{A_TCMP1, 64'h0, 32'hFFFF_FFFF};
    tbl[2] = '{A_TIER,  64'h0, 32'h0};
    tbl[3] = '{A_TISR,  64'h0, 32'h0};
    tbl[4] = '{12'h020, 64'h0, 32'h0};
    tbl[5] = '{A_TDR1,  64'hAAAA_5555_0000_0001, 32'h0};
    tbl[6] = '{A_TDR0,  64'h1234_5678_9ABC_DEF0, 32'h9ABC_DEF0};
    tbl[7] = '{A_TDR1,  64'h0000_0000_0000_0003, 32'h1234_5678};

    addrs[0] = A_TDR0; addrs[1] = A_TDR1; addrs[2] = A_TCMP0; addrs[3] = A_TCMP1;
    addrs[4] = A_TIER; addrs[5] = A_TISR; addrs[6] = 12'h020; addrs[7] = 12'h000;

    rst_n = 1'b0; addr = '0; wdata = '0; wr_en = 1'b0; rd_en = 1'b0; cnt_value = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata", 64'(rdata), 64'h0);
    chk("reset_rd_valid", 64'(rd_valid), 64'h0);
    chk("reset_tim_int", 64'(tim_int), 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset-state reads and snapshot coherence
    for (int i = 0; i < 8; i++) begin
      rd(tbl[i].a, tbl[i].cnt);
      chk("tbl_rdata", 64'(rdata), 64'(tbl[i].exp));
      chk("tbl_valid", 64'(rd_valid), 64'h1);
    end
    step(A_TIER, 32'h0, 1'b0, 1'b0, 64'h0);
    chk("rd_valid_drop", 64'(rd_valid), 64'h0);
    chk("rdata_hold", 64'(rdata), 64'h1234_5678);

    // Snapshot across a low-word carry
    rd(A_TDR0, 64'h0000_0001_FFFF_FFFF);
    chk("snap_lo", 64'(rdata), 64'hFFFF_FFFF);
    rd(A_TDR1, 64'h0000_0002_0000_0000);
    chk("snap_hi", 64'(rdata), 64'h1);

    // Ramp to compare with interrupts enabled
    wr(A_TCMP1, 32'h0, 64'h0);
    wr(A_TCMP0, 32'h10, 64'h0);
    wr(A_TIER, 32'h1, 64'h0);
    step(12'h0, 32'h0, 1'b0, 1'b0, 64'h0E);
    step(12'h0, 32'h0, 1'b0, 1'b0, 64'h0F);
    chk("ramp_pre", 64'(tim_int), 64'h0);
    step(12'h0, 32'h0, 1'b0, 1'b0, 64'h10);
    chk("ramp_hit", 64'(tim_int), 64'h1);
    rd(A_TISR, 64'h10);
    chk("ramp_st", 64'(rdata), 64'h1);

    // Clear under sustained equality, then re-arm by leaving and returning
    wr(A_TISR, 32'h1, 64'h10);
    chk("w1c_tim", 64'(tim_int), 64'h0);
    repeat (3) step(12'h0, 32'h0, 1'b0, 1'b0, 64'h10);
    rd(A_TISR, 64'h10);
    chk("w1c_stays", 64'(rdata), 64'h0);
    wr(A_TISR, 32'h0, 64'h11);
    step(12'h0, 32'h0, 1'b0, 1'b0, 64'h10);
    chk("rearm", 64'(tim_int), 64'h1);

    // Skipping over compare without equality must not set
    wr(A_TISR, 32'h1, 64'h0F);
    step(12'h0, 32'h0, 1'b0, 1'b0, 64'h11);
    chk("skip_no_set", 64'(tim_int), 64'h0);

    // Clear coinciding with a new match edge: set wins
    wr(A_TISR, 32'h1, 64'h10);
    chk("set_wins", 64'(tim_int), 64'h1);

    // Compare write equal to current count; interrupt disabled
    wr(A_TIER, 32'h0, 64'h55);
    wr(A_TISR, 32'h1, 64'h55);
    wr(A_TCMP0, 32'h55, 64'h55);
    rd(A_TISR, 64'h55);
    chk("cmpwr_n", 64'(rdata), 64'h0);
    rd(A_TISR, 64'h55);
    chk("cmpwr_n1", 64'(rdata), 64'h1);
    chk("cmpwr_masked", 64'(tim_int), 64'h0);
    wr(A_TIER, 32'h1, 64'h55);
    chk("late_enable", 64'(tim_int), 64'h1);

    // Read and write to the same register in one cycle returns the old value
    step(A_TCMP0, 32'hDEAD_BEEF, 1'b1, 1'b1, 64'h55);
    chk("rw_same", 64'(rdata), 64'h55);

    // Random traffic against the model
    c = 64'h0;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 5))
        0: c = m_cmp;
        1: c = m_cmp + 64'd1;
        2: c = m_cmp - 64'd1;
        3: c = {$urandom(), $urandom()};
        default: ;
      endcase
      ra = addrs[$urandom_range(0, 7)];
      rw = $urandom();
      if ($urandom_range(0, 3) == 0 && (ra == A_TCMP0 || ra == A_TCMP1))
        rw = (ra == A_TCMP0) ? c[31:0] : c[63:32];
      step(ra, rw, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), c);
    end

    // Reset in the middle of a pending read with the interrupt asserted
    wr(A_TCMP1, 32'h0, 64'h0);
    wr(A_TCMP0, 32'h77, 64'h0);
    wr(A_TIER, 32'h1, 64'h0);
    step(12'h0, 32'h0, 1'b0, 1'b0, 64'h77);
    rd(A_TCMP0, 64'h77);
    chk("pre_rst_tim", 64'(tim_int), 64'h1);
    chk("pre_rst_valid", 64'(rd_valid), 64'h1);
    rd_en = 1'b0; wr_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(rd_valid), 64'h0);
    chk("midrst_rdata", 64'(rdata), 64'h0);
    chk("midrst_tim", 64'(tim_int), 64'h0);
    model_reset();
    #1 rst_n = 1'b1;
    rd(A_TCMP0, 64'h77);
    chk("post_rst_cmp", 64'(rdata), 64'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule : tb_timer_cmp_rd
